// File: rtl/id_pkg.sv
// Shared definitions for the RV32I decode stage: immediate format encodings,
// default data width and the NOP bubble pattern.
package id_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

endpackage

// File: rtl/id_regfile.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to 0.
// Defining ID_RF_BYPASS_EN forwards same-cycle writeback data straight to the read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   writedata,
    input  logic              regwrite,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regwrite && (rd != '0)) begin
            regs[rd] <= writedata;
        end
    end

    always_comb begin
        stored1 = (rs1 == '0) ? '0 : regs[rs1];
        stored2 = (rs2 == '0) ? '0 : regs[rs2];
`ifdef ID_RF_BYPASS_EN
        rd1 = (regwrite && (rd != '0) && (rd == rs1)) ? writedata : stored1;
        rd2 = (regwrite && (rd != '0) && (rd == rs2)) ? writedata : stored2;
`else
        rd1 = stored1;
        rd2 = stored2;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, register file and immediate extender.
// Optional macro ID_RF_BYPASS_EN enables writeback-to-read forwarding in the register file.
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [XLEN-1:0]       InstrF,
    input  logic [XLEN-1:0]       PCF,
    input  logic [XLEN-1:0]       PCplus4F,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       writedata,
    input  logic                  regwrite,
    input  logic [1:0]            immsrc,
    output logic [XLEN-1:0]       InstrD,
    output logic [XLEN-1:0]       PCD,
    output logic [XLEN-1:0]       PCplus4D,
    output logic [REG_ADDR_W-1:0] rs1D,
    output logic [REG_ADDR_W-1:0] rs2D,
    output logic [REG_ADDR_W-1:0] rdD,
    output logic [XLEN-1:0]       rd1,
    output logic [XLEN-1:0]       rd2,
    output logic [XLEN-1:0]       imm_data
);

    // Flush wins over stall so a squashed instruction never survives a held pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCplus4D <= '0;
        end else if (clr) begin
            InstrD   <= XLEN'(NOP_INSTR);
            PCD      <= '0;
            PCplus4D <= '0;
        end else if (!en) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCplus4D <= PCplus4F;
        end
    end

    assign rs1D = InstrD[19:15];
    assign rs2D = InstrD[24:20];
    assign rdD  = InstrD[11:7];

    id_regfile #(
        .XLEN   (XLEN),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1D),
        .rs2       (rs2D),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    always_comb begin
        imm_data = '0;
        case (imm_src_e'(immsrc))
            IMM_I: imm_data = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_data = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_data = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                               InstrD[11:8], 1'b0};
            IMM_J: imm_data = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                               InstrD[30:21], 1'b0};
            default: imm_data = '0;
        endcase
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a high-level model queues expected outputs for the
// pre-edge and post-edge samples of every cycle; an independent monitor pops and compares.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        en;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCplus4F;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic        regwrite;
    logic [1:0]  immsrc;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCplus4D;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rdD;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          pre;
        int          cyc;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    int          cycle_no = 0;

    id_stage dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (en),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCplus4F  (PCplus4F),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .immsrc    (immsrc),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCplus4D  (PCplus4D),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rdD       (rdD),
        .rd1       (rd1),
        .rd2       (rd2),
        .imm_data  (imm_data)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int cyc,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Immediate value as a signed offset built from weighted instruction fields.
    function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [1:0] sel);
        int v;
        case (sel)
            2'b00: v = int'(i[30:20]) - (i[31] ? 2048 : 0);
            2'b01: v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
            2'b10: v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2
                       - (i[31] ? 4096 : 0);
            default: v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                       - (i[31] ? 1048576 : 0);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_RF_BYPASS_EN
        if (regwrite && rd == idx) return writedata;
`endif
        return m_regs[idx];
    endfunction

    function automatic exp_t model_outputs(input bit pre);
        exp_t e;
        e.pre   = pre;
        e.cyc   = cycle_no;
        e.instr = m_instr;
        e.pc    = m_pc;
        e.pc4   = m_pc4;
        e.rd1   = model_read(m_instr[19:15]);
        e.rd2   = model_read(m_instr[24:20]);
        e.imm   = model_imm(m_instr, immsrc);
        return e;
    endfunction

    task automatic apply_stimulus(input bit c, input bit e, input logic [31:0] ins,
                                  input logic [31:0] p, input logic [31:0] p4,
                                  input logic [4:0] r, input logic [31:0] wd,
                                  input bit rw, input logic [1:0] is);
        @(negedge clk);
        cycle_no++;
        clr = c; en = e; InstrF = ins; PCF = p; PCplus4F = p4;
        rd = r; writedata = wd; regwrite = rw; immsrc = is;
        exp_q.push_back(model_outputs(1'b1));
        if (rw && r != 5'd0) m_regs[r] = wd;
        if (c) begin
            m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
        end else if (!e) begin
            m_instr = ins; m_pc = p; m_pc4 = p4;
        end
        exp_q.push_back(model_outputs(1'b0));
    endtask

    task automatic compare_item(input exp_t e);
        string ph;
        ph = e.pre ? "pre" : "post";
        check_output({ph, "_InstrD"},   e.cyc, InstrD,   e.instr);
        check_output({ph, "_PCD"},      e.cyc, PCD,      e.pc);
        check_output({ph, "_PCplus4D"}, e.cyc, PCplus4D, e.pc4);
        check_output({ph, "_rs1D"},     e.cyc, {27'h0, rs1D}, {27'h0, e.instr[19:15]});
        check_output({ph, "_rs2D"},     e.cyc, {27'h0, rs2D}, {27'h0, e.instr[24:20]});
        check_output({ph, "_rdD"},      e.cyc, {27'h0, rdD},  {27'h0, e.instr[11:7]});
        check_output({ph, "_rd1"},      e.cyc, rd1,      e.rd1);
        check_output({ph, "_rd2"},      e.cyc, rd2,      e.rd2);
        check_output({ph, "_imm"},      e.cyc, imm_data, e.imm);
    endtask

    // Monitor: pre-edge sample just after inputs settle, post-edge sample just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0 && exp_q[0].pre) compare_item(exp_q.pop_front());
            @(posedge clk);
            #1;
            if (exp_q.size() > 0 && !exp_q[0].pre) compare_item(exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] ins;
        reset = 1'b0; clr = 1'b0; en = 1'b0; InstrF = '0; PCF = '0; PCplus4F = '0;
        rd = '0; writedata = '0; regwrite = 1'b0; immsrc = 2'b00;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
        #1;
        check_output("reset_InstrD",   0, InstrD,   32'h0);
        check_output("reset_PCD",      0, PCD,      32'h0);
        check_output("reset_PCplus4D", 0, PCplus4D, 32'h0);
        check_output("reset_imm",      0, imm_data, 32'h0);
        check_output("reset_rd1",      0, rd1,      32'h0);
        check_output("reset_rd2",      0, rd2,      32'h0);
        #2;
        reset = 1'b1;

        apply_stimulus(0, 0, 32'h0, 32'h0, 32'h0, 5'd1, 32'hCAFEBABE, 1, 2'b00);
        apply_stimulus(0, 0, 32'h00508093, 32'h10, 32'h14, 5'd0, 32'h0, 0, 2'b00);
        apply_stimulus(0, 1, 32'h0020A023, 32'h20, 32'h24, 5'd0, 32'h0, 0, 2'b00);
        apply_stimulus(0, 0, 32'h0020A023, 32'h20, 32'h24, 5'd2, 32'h55AA0011, 1, 2'b01);
        apply_stimulus(0, 0, 32'h00208663, 32'h30, 32'h34, 5'd0, 32'h0, 0, 2'b10);
        apply_stimulus(0, 0, 32'hFE000EE3, 32'h40, 32'h44, 5'd0, 32'h0, 0, 2'b10);
        apply_stimulus(0, 0, 32'hFFF00093, 32'h50, 32'h54, 5'd0, 32'h1234, 1, 2'b11);
        apply_stimulus(1, 1, 32'h12345678, 32'h60, 32'h64, 5'd0, 32'h0, 0, 2'b00);
        apply_stimulus(0, 0, 32'h00018093, 32'h70, 32'h74, 5'd3, 32'h11111111, 1, 2'b00);
        apply_stimulus(0, 1, 32'h00018093, 32'h70, 32'h74, 5'd3, 32'hA5A5A5A5, 1, 2'b00);
        apply_stimulus(0, 1, 32'h00018093, 32'h70, 32'h74, 5'd0, 32'h0, 0, 2'b00);

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            apply_stimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, ins,
                           $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom,
                           $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d pending expected=0", exp_q.size());
        end

        @(negedge clk);
        regwrite = 1'b0;
        reset = 1'b0;
        #1;
        check_output("late_reset_InstrD", cycle_no, InstrD,   32'h0);
        check_output("late_reset_PCD",    cycle_no, PCD,      32'h0);
        check_output("late_reset_rd1",    cycle_no, rd1,      32'h0);
        check_output("late_reset_rd2",    cycle_no, rd2,      32'h0);
        check_output("late_reset_imm",    cycle_no, imm_data, 32'h0);
        reset = 1'b1;
        en = 1'b0; clr = 1'b0; InstrF = 32'h0001A093; immsrc = 2'b00;
        @(posedge clk);
        #1;
        check_output("late_reset_x3_cleared", cycle_no, rd1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
